// File: rtl/fft_pkg.sv
// fft_pkg: FSM state encoding and size helpers shared by the FFT butterfly sequencer.
package fft_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction
  function automatic int stage_w(input int n);
    return $clog2($clog2(n));
  endfunction
endpackage

// File: rtl/fft_bf_delay.sv
// fft_bf_delay: fixed-depth shift line carrying butterfly valid, last-pair flag and address pair.
module fft_bf_delay #(
  parameter int W = 5,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         v_i,
  input  logic         last_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         v_o,
  output logic         last_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o
);
  logic [L-1:0] v_q, l_q;
  logic [W-1:0] a_q [L];
  logic [W-1:0] b_q [L];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < L; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0] <= v_i;
      l_q[0] <= last_i;
      a_q[0] <= a_i;
      b_q[0] <= b_i;
      for (int i = 1; i < L; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  assign v_o    = v_q[L-1];
  assign last_o = l_q[L-1];
  assign a_o    = a_q[L-1];
  assign b_o    = b_q[L-1];
endmodule

// File: rtl/fft_bf_sequencer.sv
// fft_bf_sequencer: radix-2 in-place FFT butterfly address sequencer with writeback delay line.
// Optional FFT_SEQ_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module fft_bf_sequencer
  import fft_pkg::*;
#(
  parameter int N          = 32,
  parameter int BF_LATENCY = 4,
  localparam int LG        = log2n(N),
  localparam int SW        = stage_w(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          rd_valid,
  output logic [LG-1:0] rd_addr_a,
  output logic [LG-1:0] rd_addr_b,
  output logic [LG-2:0] tw_addr,
  output logic          wb_valid,
  output logic [LG-1:0] wb_addr_a,
  output logic [LG-1:0] wb_addr_b
`ifdef FFT_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_cycles
`endif
);
  localparam logic [LG-2:0] PMAX = '1;
  localparam logic [SW-1:0] SMAX = SW'(LG - 1);
  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [LG-2:0] pair_q, pair_d;
  logic [LG-1:0] pe, hm, a;
  logic          wb_last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
    end
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    unique case (state_q)
      IDLE:
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          pair_d  = '0;
        end
      ISSUE:
        if (!stall) begin
          pair_d  = pair_q + 1'b1;
          state_d = pair_q == PMAX ? DRAIN : ISSUE;
        end
      DRAIN:
        if (wb_last) begin
          pair_d  = '0;
          state_d = stage_q == SMAX ? DONE : ISSUE;
          stage_d = stage_q == SMAX ? '0 : stage_q + 1'b1;
        end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // a = pair with a zero bit inserted at position stage; b sets that bit
  always_comb begin
    pe        = {1'b0, pair_q};
    hm        = (LG'(1) << stage_q) - LG'(1);
    a         = (((pe >> stage_q) << stage_q) << 1) + (pe & hm);
    rd_valid  = state_q == ISSUE && !stall;
    rd_addr_a = rd_valid ? a : '0;
    rd_addr_b = rd_valid ? a + (LG'(1) << stage_q) : '0;
    tw_addr   = rd_valid ? (pair_q & hm[LG-2:0]) << (SMAX - stage_q) : '0;
  end
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
  assign stage = stage_q;
  fft_bf_delay #(.W(LG), .L(BF_LATENCY)) u_dly (
    .clk    (clk),
    .reset_n(reset_n),
    .v_i    (rd_valid),
    .last_i (rd_valid && pair_q == PMAX),
    .a_i    (rd_addr_a),
    .b_i    (rd_addr_b),
    .v_o    (wb_valid),
    .last_o (wb_last),
    .a_o    (wb_addr_a),
    .b_o    (wb_addr_b)
  );
`ifdef FFT_SEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) perf_q <= '0;
    else if (state_q == IDLE && start) perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 1'b1;
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// tb_fft_bf_sequencer: directed checks of the N=32, BF_LATENCY=4 butterfly sequencer.
module tb_fft_bf_sequencer;
  localparam int N = 32, L = 4;
  logic       clk = 0, reset_n = 0, start = 0, stall = 0;
  logic       busy, done, rd_valid, wb_valid;
  logic [2:0] stage;
  logic [4:0] rd_addr_a, rd_addr_b, wb_addr_a, wb_addr_b;
  logic [3:0] tw_addr;
`ifdef FFT_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif
  fft_bf_sequencer #(.N(N), .BF_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .busy(busy), .done(done), .stage(stage), .rd_valid(rd_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wb_valid(wb_valid), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b)
`ifdef FFT_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int c; logic [4:0] a; logic [4:0] b;} rd_t;
  rd_t q[$];
  int  n_vec = 0, n_bad = 0;
  int  seen[5][32];
  int  first_rd, last_wb, done_cyc, n_done, n_rd, wb_after;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
              wb_valid, wb_addr_a, wb_addr_b}, 0);
  endtask
  task automatic run(input int stl_at, input int stl_n, input int rst_at, input bit extra);
    rd_t e;
    first_rd = -1; last_wb = -1; done_cyc = -1;
    n_done = 0; n_rd = 0; wb_after = 0;
    q.delete();
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 32; a++) seen[s][a] = 0;
    @(negedge clk);
    start = 1; stall = 0; reset_n = 1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      start   = extra && (c == 50 || c == 101);
      stall   = stl_n > 0 && c >= stl_at && c < stl_at + stl_n;
      reset_n = c != rst_at;
      #1;
      if (c == rst_at) begin
        chk_zero("rst_mid_outputs");
        q.delete();
      end
      if (stall) chk("stall_rd_valid", rd_valid, 0);
      if (c == 50 && rst_at == 0) chk("busy_mid", busy, 1);
      if (rd_valid) begin
        if (first_rd < 0) first_rd = c;
        chk("rd_stage", stage, n_rd / 16);
        if (stage < 5) begin
          seen[stage][rd_addr_a]++;
          seen[stage][rd_addr_b]++;
        end
        case (n_rd)
          0:  begin chk("s0p0_a", rd_addr_a, 0);  chk("s0p0_b", rd_addr_b, 1);  chk("s0p0_tw", tw_addr, 0);  end
          19: begin chk("s1p3_a", rd_addr_a, 5);  chk("s1p3_b", rd_addr_b, 7);  chk("s1p3_tw", tw_addr, 8);  end
          37: begin chk("s2p5_a", rd_addr_a, 9);  chk("s2p5_b", rd_addr_b, 13); chk("s2p5_tw", tw_addr, 4);  end
          58: begin chk("s3p10_a", rd_addr_a, 18); chk("s3p10_b", rd_addr_b, 26); chk("s3p10_tw", tw_addr, 4); end
          79: begin chk("s4p15_a", rd_addr_a, 15); chk("s4p15_b", rd_addr_b, 31); chk("s4p15_tw", tw_addr, 15); end
          default: ;
        endcase
        e.c = c; e.a = rd_addr_a; e.b = rd_addr_b;
        q.push_back(e);
        n_rd++;
      end
      if (wb_valid) begin
        last_wb = c;
        if (rst_at > 0 && c > rst_at) wb_after++;
        chk("wb_has_read", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wb_latency", c - e.c, L);
          chk("wb_addr_a", wb_addr_a, e.a);
          chk("wb_addr_b", wb_addr_b, e.b);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = c;
        chk("done_stage", stage, 0);
      end
    end
    chk("idle_at_end", busy, 0);
  endtask
  function automatic int covered();
    int k = 0;
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 32; a++) k += int'(seen[s][a] == 1);
    return k;
  endfunction
  initial begin
    #1;
    chk_zero("reset_outputs");
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset_held");
    run(0, 0, 0, 0);
    chk("r1_first_rd", first_rd, 1);
    chk("r1_last_wb", last_wb, 100);
    chk("r1_done_cyc", done_cyc, 101);
    chk("r1_done_cnt", n_done, 1);
    chk("r1_reads", n_rd, 80);
    chk("r1_cover", covered(), 160);
`ifdef FFT_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, 101);
`endif
    run(25, 3, 0, 0);
    chk("stl_last_wb", last_wb, 103);
    chk("stl_done_cyc", done_cyc, 104);
    chk("stl_reads", n_rd, 80);
    chk("stl_cover", covered(), 160);
    run(0, 0, 40, 0);
    chk("rst_done_cnt", n_done, 0);
    chk("rst_wb_after", wb_after, 0);
    run(0, 0, 0, 0);
    chk("rr_last_wb", last_wb, 100);
    chk("rr_done_cyc", done_cyc, 101);
    chk("rr_cover", covered(), 160);
    run(0, 0, 0, 1);
    chk("xs_done_cnt", n_done, 1);
    chk("xs_done_cyc", done_cyc, 101);
    chk("xs_reads", n_rd, 80);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_bf_sequencer.md
FFT_BF_SEQUENCER -- requirements
Module: fft_bf_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning FFT points (power of two, 8 to 1024).
REQ-002 SHALL have parameter BF_LATENCY, default 4, meaning butterfly pipeline depth in cycles (1 to 16).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begin one FFT (sampled only in IDLE).
REQ-006 SHALL have port stall, input, 1, suppress issue this cycle.
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse on completion.
REQ-009 SHALL have port stage, output, $clog2($clog2(N)), current stage index.
REQ-010 SHALL have port rd_valid, output, 1, butterfly operand read issued.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, output, $clog2(N) each, operand addresses.
REQ-012 SHALL have port tw_addr, output, $clog2(N)-1, twiddle ROM index.
REQ-013 SHALL have port wb_valid, output, 1, butterfly result writeback strobe.
REQ-014 SHALL have ports wb_addr_a and wb_addr_b, output, $clog2(N) each, writeback addresses.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 -> ISSUE, stage=0, pair=0; start while busy SHALL be ignored.
REQ-017 ISSUE: each cycle with stall=0 SHALL assert rd_valid and increment pair; stall=1 -> rd_valid=0, pair held.
REQ-018 Addressing for stage s, pair p: half=2^s, a=((p>>s)<<(s+1))+(p&(half-1)), b=a+half, tw=(p&(half-1))<<(log2N-1-s).
REQ-019 After issuing pair N/2-1 -> DRAIN.
REQ-020 wb_valid/wb_addr_a/wb_addr_b SHALL equal rd_valid/rd_addr_a/rd_addr_b delayed exactly BF_LATENCY cycles; the delay SHALL not be affected by stall.
REQ-021 DRAIN: leave in the cycle after the last pair's wb_valid; -> ISSUE with stage+1, pair=0 if stage<log2N-1, else -> DONE.
REQ-022 No read of stage s+1 SHALL be issued in the same cycle as or before any writeback of stage s (read-after-write safety).
REQ-023 DONE: done=1 for exactly one cycle, stage=0, -> IDLE; start in DONE ignored.
REQ-024 Unstalled run SHALL take (N/2+BF_LATENCY)*log2N cycles from start sample to last wb_valid; done follows in the next cycle.
REQ-025 Address arithmetic SHALL be unsigned, width $clog2(N); no overflow is possible by construction.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, and set busy, done, stage, rd_valid, rd_addr_a/b, tw_addr, wb_valid, and wb_addr_a/b to 0; it SHALL clear the delay line.
REQ-027 Reset mid-operation SHALL discard in-flight writebacks; no wb_valid after release until a new start.

Configuration
REQ-028 Macro FFT_SEQ_PERF_EN defined: add output perf_cycles, 16 bits, cleared on start, incremented each busy cycle, saturating at 0xFFFF, held after done until the next start.
REQ-029 Macro undefined: no perf_cycles port and no counter logic.

Structure
REQ-030 Package fft_pkg SHALL hold the state enum and the log2N and stage-width helper constants.
REQ-031 Sub-module fft_bf_delay SHALL implement the BF_LATENCY-deep valid+address shift line with async-low clear.

Verification
REQ-032 N=32, L=4, start one cycle, no stall -> rd_valid first seen at cycle 1; stage0 pair0 a=0,b=1,tw=0; last wb_valid at cycle 100; done at cycle 101.
REQ-033 Stage 2, pair 5 -> a=9, b=13, tw=4; stage 4, pair 15 -> a=15, b=31, tw=15.
REQ-034 Stall held 3 cycles mid stage 1 -> pair index frozen, no duplicated or skipped address, completion delayed exactly 3 cycles.
REQ-035 reset_n low at cycle 40 -> all outputs 0 that cycle; no wb_valid afterward; a new start gives the full 101-cycle run.
REQ-036 start pulsed while busy and during DONE -> ignored; done pulses exactly once per accepted start.
REQ-037 FFT_SEQ_PERF_EN defined, unstalled N=32, L=4 run -> perf_cycles=101 after done.
